// File: rtl/psum_accum.sv
// psum_accum
// Accumulates corelet output rows across kij kernel passes in a local buffer,
// then drains the ReLU'd result rows toward psum SRAM writeback.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   start           begin a job (only honoured while idle)
//   in_valid        corelet OFIFO holds a row
//   in_data         show-ahead corelet row, col lanes of psum_bw bits
//   in_rd           combinational consume strobe back to the OFIFO
//   out_data        registered ReLU'd accumulated row
//   out_valid       out_data holds a row
//   out_ready       downstream accepts out_data
//   busy            job in progress
//   done            one-cycle pulse after the last row has drained
module psum_accum #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int kij     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [psum_bw*col-1:0] in_data,
  output logic                   in_rd,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int PW = (kij > 1) ? $clog2(kij) : 1;
  localparam int RW = psum_bw * col;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;
  logic [PW-1:0]   pass_reg;
  logic [RW-1:0]   buf_mem [depth];
  logic [RW-1:0]   out_data_reg;
  logic            out_valid_reg;
  logic            done_reg;

  logic            addr_last;
  logic            pass_last;
  logic [RW-1:0]   wr_row;
  logic [AW-1:0]   rd_idx;
  logic [RW-1:0]   row_src;
  logic [RW-1:0]   relu_row;

  assign in_rd     = (state_reg == ACC) && in_valid;
  assign addr_last = (addr_reg == AW'(depth - 1));
  assign pass_last = (pass_reg == PW'(kij - 1));

  // Per-lane write value: overwrite on the first pass, saturating add after.
  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic signed [psum_bw-1:0] old_v;
    logic signed [psum_bw-1:0] new_v;
    logic signed [psum_bw:0]   sum_v;
    logic [psum_bw-1:0]        sat_v;

    assign old_v = buf_mem[addr_reg][gi*psum_bw +: psum_bw];
    assign new_v = in_data[gi*psum_bw +: psum_bw];
    assign sum_v = {old_v[psum_bw-1], old_v} + {new_v[psum_bw-1], new_v};

    // Overflow when the extra sign bit disagrees with the lane's top bit.
    always_comb begin
      sat_v = sum_v[psum_bw-1:0];
      if (sum_v[psum_bw] != sum_v[psum_bw-1]) begin
        sat_v = sum_v[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                               : {1'b0, {(psum_bw-1){1'b1}}};
      end
    end

    assign wr_row[gi*psum_bw +: psum_bw] = (pass_reg == '0) ? new_v : sat_v;
  end

  // Row to present next: row 0 when leaving ACC, otherwise the following row.
  always_comb begin
    rd_idx = '0;
    if (state_reg == DRAIN && !addr_last) begin
      rd_idx = addr_reg + AW'(1);
    end
  end

  // Bypass covers a single-entry buffer whose only row is written this cycle.
  assign row_src = (in_rd && addr_reg == rd_idx) ? wr_row : buf_mem[rd_idx];

  for (genvar gi = 0; gi < col; gi++) begin : g_relu
    assign relu_row[gi*psum_bw +: psum_bw] =
      row_src[gi*psum_bw + psum_bw - 1] ? '0 : row_src[gi*psum_bw +: psum_bw];
  end

  // Buffer is left uncleared by reset; pass 0 overwrites every entry.
  always_ff @(posedge clk) begin
    if (in_rd) begin
      buf_mem[addr_reg] <= wr_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      pass_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= ACC;
            addr_reg  <= '0;
            pass_reg  <= '0;
          end
        end
        ACC: begin
          if (in_rd) begin
            if (addr_last) begin
              addr_reg <= '0;
              if (pass_last) begin
                pass_reg      <= '0;
                state_reg     <= DRAIN;
                out_valid_reg <= 1'b1;
                out_data_reg  <= relu_row;
              end else begin
                pass_reg <= pass_reg + PW'(1);
              end
            end else begin
              addr_reg <= addr_reg + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_valid_reg && out_ready) begin
            if (addr_last) begin
              addr_reg      <= '0;
              state_reg     <= DONE;
              out_valid_reg <= 1'b0;
              out_data_reg  <= '0;
              done_reg      <= 1'b1;
            end else begin
              addr_reg     <= addr_reg + AW'(1);
              out_data_reg <= relu_row;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;
  localparam int W = 16;
  localparam int C = 8;
  localparam int D = 16;
  localparam int K = 9;
  localparam int N = K * D;
  localparam int BOUND = 4000;

  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic in_valid = 0;
  logic [W*C-1:0] in_data = '0;
  logic in_rd;
  logic [W*C-1:0] out_data;
  logic out_valid;
  logic out_ready = 0;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_exp = 0;

  int data_mem [N][C];
  int acc_mem [D][C];

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  psum_accum #(.psum_bw(W), .col(C), .depth(D), .kij(K)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_rd(in_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [W*C-1:0] got, input logic [W*C-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_s(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return int'($signed(t));
  endfunction

  // mode 0: all +2, 1: lane0 -5 lane1 +7, 2: lane3 0x7000 lane4 0x9000,
  // 3: full-range random, 4: small random
  task automatic gen_data(input int mode);
    for (int n = 0; n < N; n++)
      for (int l = 0; l < C; l++) begin
        case (mode)
          0: data_mem[n][l] = 2;
          1: data_mem[n][l] = (l == 0) ? -5 : (l == 1) ? 7 : 0;
          2: data_mem[n][l] = (l == 3) ? 'h7000 : (l == 4) ? to_s('h9000) : 0;
          3: data_mem[n][l] = to_s(int'($urandom));
          default: data_mem[n][l] = int'($urandom_range(0, 400)) - 200;
        endcase
      end
    for (int a = 0; a < D; a++)
      for (int l = 0; l < C; l++) begin
        acc_mem[a][l] = 0;
        for (int p = 0; p < K; p++) begin
          int s;
          s = (p == 0) ? data_mem[a][l] : acc_mem[a][l] + data_mem[p*D + a][l];
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          acc_mem[a][l] = s;
        end
      end
  endtask

  function automatic logic [W*C-1:0] in_row(input int n);
    logic [W*C-1:0] r;
    for (int l = 0; l < C; l++) r[l*W +: W] = data_mem[n][l][W-1:0];
    return r;
  endfunction

  function automatic logic [W*C-1:0] exp_row(input int a);
    logic [W*C-1:0] r;
    for (int l = 0; l < C; l++)
      r[l*W +: W] = (acc_mem[a][l] < 0) ? '0 : acc_mem[a][l][W-1:0];
    return r;
  endfunction

  // Feeds rows until 'limit' have been consumed; vprob = percent in_valid high.
  task automatic feed(input int limit, input int vprob, input bit poke_start, output int rd_cnt);
    int idx = 0;
    int cyc = 0;
    rd_cnt = 0;
    while (idx < limit && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      start = poke_start && ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(1, 100) <= vprob);
      in_data = in_row(idx);
      #1;
      check("in_rd", in_rd, in_valid);
      @(posedge clk);
      if (in_rd) rd_cnt++;
      if (in_valid) idx++;
    end
    if (idx < limit) check("acc_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
    start = 0;
  endtask

  task automatic drain(input bit poke_start);
    int r = 0;
    int cyc = 0;
    int stall_left = 3;
    while (r < D && cyc < BOUND) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (r == 5 && stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      start = poke_start && ($urandom_range(0, 7) == 0);
      #1;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_row(r));
      check("in_rd_drain", in_rd, 0);
      @(posedge clk);
      if (out_ready) r++;
    end
    if (r < D) check("drain_timeout", 0, 1);
    @(negedge clk);
    out_ready = 0;
    start = 1;  // coincides with DONE; must be ignored
    #1;
    check("done_pulse", done, 1);
    check("out_valid_done", out_valid, 0);
    check("busy_done", busy, 1);
    done_exp++;
    @(negedge clk);
    start = 0;
    #1;
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("done_count", done_cnt, done_exp);
  endtask

  task automatic run_job(input int mode, input int vprob, input bit poke_start);
    int rd_cnt;
    gen_data(mode);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    feed(N, vprob, poke_start, rd_cnt);
    check("rd_count", rd_cnt, N);
    drain(poke_start);
    $display("job mode=%0d vprob=%0d rd=%0d errors=%0d", mode, vprob, rd_cnt, errors);
  endtask

  initial begin
    int rd_cnt;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_rd", in_rd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);

    // Abort a job at pass 3, addr 5, then rerun with fresh data.
    gen_data(3);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    feed(3*D + 5, 100, 0, rd_cnt);
    in_valid = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_rd", in_rd, 0);
    check("mid_rst_out_valid", out_valid, 0);
    in_valid = 0;
    $display("reset mid-ACC after %0d rows", rd_cnt);

    run_job(4, 100, 0);
    run_job(0, 100, 0);
    run_job(1, 70, 0);
    run_job(2, 60, 1);
    run_job(3, 50, 1);
    run_job(4, 40, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Consumes the corelet's output-FIFO rows (one col-wide row of psums per output position) and accumulates them across kernel passes (kij) in an internal buffer.
- Emits final ReLU'd rows toward psum SRAM writeback.
- Sits directly downstream of the corelet. Its rd output drives the corelet OFIFO read bit (inst[6]) through the controller.

Parameters:
psum_bw, 16, width of one signed psum lane
col, 8, lanes per row
depth, 16, output positions per pass (buffer entries)
kij, 9, accumulation passes per job

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin job; sampled only in IDLE
in_valid  input  1  corelet OFIFO has a row (o_valid)
in_data  input  psum_bw*col  corelet row; show-ahead, valid while in_valid
in_rd  output  1  consume in_data this cycle (to OFIFO rd)
out_data  output  psum_bw*col  ReLU'd accumulated row
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after last row drained

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset (any state, including mid-job):
  - state=IDLE; addr=0; pass=0.
  - in_rd=0, out_valid=0, out_data=0, busy=0, done=0.
  - Buffer contents are not cleared; pass 0 overwrites them.
- Storage: depth x (psum_bw*col) register buffer; addr counter 0..depth-1; pass counter 0..kij-1.
- States: IDLE, ACC, DRAIN, DONE.
- IDLE:
  - start=1 -> ACC next cycle, with addr=0, pass=0.
  - start while busy is ignored.
- ACC:
  - in_rd = in_valid (combinational, ACC only). Zero-latency consume.
  - On in_rd: lane i of buf[addr] is written.
    - pass==0: buf[addr] = in_data (overwrite).
    - pass>0: buf[addr] = sat(buf[addr] + in_data), per lane.
  - Then addr++.
  - When addr==depth-1 is consumed: addr=0, pass++.
  - When addr==depth-1 and pass==kij-1 are consumed: DRAIN, addr=0.
  - in_valid=0 stalls with no state change.
- Arithmetic:
  - Lanes are signed two's complement, psum_bw bits, independent; no carry across lanes.
  - Sum is computed at psum_bw+1 bits.
  - Saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- DRAIN:
  - out_valid=1; out_data = relu(buf[addr]) per lane (negative -> 0), registered.
  - in_rd=0.
  - out_valid && out_ready -> addr++, next row presented next cycle.
  - out_data is held stable while out_ready=0.
  - Last row accepted -> DONE.
- DONE: done=1 for exactly one cycle, out_valid=0 -> IDLE.
- start coincident with the DONE cycle is ignored; a new job must start from IDLE.
- busy=1 in ACC, DRAIN, DONE.
- Latency: first out_valid appears 1 cycle after the final ACC consume.
- Throughput: 1 row/cycle in ACC and in DRAIN.

Test Plan:
- Reset mid-ACC (pass=3, addr=5) -> next cycle busy=0, in_rd=0, out_valid=0. New start plus a full job gives correct sums with no stale data.
- kij=9, depth=16, every lane of every row = +2, in_valid continuous -> in_rd high 144 cycles, then 16 rows of 0x0012 per lane, done one cycle after the 16th accept.
- Lane 0 = -5 every pass, lane 1 = +7 -> lane 0 out 0 (ReLU), lane 1 out 63. Other lanes (0) out 0; lane isolation confirmed.
- Every pass sends 0x7000 to lane 3 -> lane 3 saturates at 0x7FFF, no wrap. Every pass sends 0x9000 -> saturates at 0x8000 internally, out 0.
- in_valid toggled 1/0 randomly during ACC, out_ready low 3 cycles mid-DRAIN -> in_rd never high with in_valid low. Counters advance only on handshakes. out_data constant while stalled, and rows emerge in addr order 0..15.
- start pulsed during ACC and DRAIN -> ignored; pass/addr unaffected; exactly one done pulse per job.
